fir_decimator: RTL

Downstream stage of the FIR filter. It takes the filter's 16-bit output stream (a one-cycle `valid` pulse per sample) and keeps every DECIM-th sample. Kept samples are buffered in a small first-word-fall-through FIFO and presented to the consumer over a valid/ready handshake. Overflow is reported, never stalls the filter: the filter has no backpressure input.

---
 rtl/fir_decimator.sv | 113 +++++++++++
 1 files changed

// File: rtl/fir_decimator.sv
// ---------------------------------------------------------------------------
// fir_decimator
//
// Keeps every DECIM-th sample of the FIR output stream and buffers the kept
// samples in a DEPTH-entry first-word-fall-through FIFO. The FIFO drains over
// a valid/ready handshake. The upstream filter cannot be stalled, so a kept
// sample that finds the FIFO full is dropped and flagged in a sticky bit.
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous active-low reset, clears all state
//   in_valid    single-cycle strobe qualifying in_sample
//   in_sample   filter output sample, two's complement
//   out_valid   FIFO head is valid
//   out_ready   consumer accepts the head this cycle
//   out_sample  FIFO head, held while out_valid && !out_ready
//   level       FIFO occupancy, 0..DEPTH
//   overflow    sticky: a kept sample was dropped because the FIFO was full
//   ovf_clr     synchronous clear of overflow (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module fir_decimator #(
   parameter int DECIM  = 4,
   parameter int DEPTH  = 8,
   parameter int DATA_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic signed [DATA_W-1:0]   in_sample,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [DATA_W-1:0]   out_sample,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   input  logic                       ovf_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

   logic [PW-1:0]            phase;
   logic [AW-1:0]            wptr;
   logic [AW-1:0]            rptr;
   logic signed [DATA_W-1:0] mem [DEPTH];

   logic keep;
   logic pop;
   logic full;
   logic accept;
   logic drop;

   assign keep   = in_valid && (phase == '0);
   assign pop    = out_valid && out_ready;
   assign full   = (level == LW'(DEPTH));
   // A pop in the same cycle frees the slot the push needs, so full only
   // blocks the push when nothing leaves.
   assign accept = keep && (!full || pop);
   assign drop   = keep && full && !pop;

   assign out_valid  = (level != '0);
   assign out_sample = mem[rptr];

   // Phase advances on every valid sample, including dropped ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase <= '0;
      end else if (in_valid) begin
         if (phase == PW'(DECIM - 1))
            phase <= '0;
         else
            phase <= phase + 1'b1;
      end
   end

   // Storage is cleared too so the head reads zero after reset while empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (accept) begin
         mem[wptr] <= in_sample;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (accept)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         if (accept && !pop)
            level <= level + 1'b1;
         else if (pop && !accept)
            level <= level - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         overflow <= 1'b0;
      else if (drop)
         overflow <= 1'b1;
      else if (ovf_clr)
         overflow <= 1'b0;
   end

endmodule
